// File: rtl/remap_pkg.sv
// Shared definitions for the remap lookup-table bank.
// Contents:
//   state_t  - controller state encoding (CLEAR / IDLE / LOAD)
//   DROP_W   - width of the saturating dropped-write counter
package remap_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam int DROP_W = 8;

endpackage

// File: rtl/remap_lut_mem.sv
// Remap table storage: one write port and N_RD registered, write-first read
// ports. A read whose address matches the write in the same cycle returns
// the data being written.
// Ports:
//   okClk  in   clock, rising edge
//   reset  in   synchronous active-high; zeroes the read registers only
//   we     in   write enable
//   waddr  in   [ADDR_W]         write address
//   wdata  in   [DATA_W]         write data
//   raddr  in   [N_RD*ADDR_W]    read address, port r at [r*ADDR_W +: ADDR_W]
//   rdata  out  [N_RD*DATA_W]    registered read data, port r at [r*DATA_W +: DATA_W]
module remap_lut_mem #(
    parameter int DATA_W = 7,
    parameter int ADDR_W = 7,
    parameter int N_RD   = 3
) (
    input  logic                     okClk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [N_RD*ADDR_W-1:0]   raddr,
    output logic [N_RD*DATA_W-1:0]   rdata
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge okClk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read stage: bypass the write data so same-cycle readers see new contents.
    always_ff @(posedge okClk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            for (int r = 0; r < N_RD; r++) begin
                if (we && (raddr[r*ADDR_W +: ADDR_W] == waddr)) begin
                    rdata[r*DATA_W +: DATA_W] <= wdata;
                end else begin
                    rdata[r*DATA_W +: DATA_W] <= mem[raddr[r*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

endmodule

// File: rtl/remap_lut_bank.sv
// DEPTH x DATA_W remap table with N_CH registered lookup channels, a
// sequential clear controller, a streamed bulk-load mode and a registered
// debug readback port.
// Ports:
//   okClk, reset              clock; synchronous active-high reset
//   clear                     pulse: zero the table one entry per cycle
//   wr_en/wr_addr/wr_data     single-entry write (honoured only in IDLE)
//   ld_start                  pulse: enter bulk-load, pointer to 0
//   ld_valid/ld_data          bulk-load stream; ld_ready high while loading
//   ld_done                   one-cycle pulse after the last entry is loaded
//   busy                      high while clearing or loading
//   lk_valid/lk_addr          per-channel lookup request
//   lk_rvalid/lk_data         per-channel registered response (1-cycle latency)
//   dbg_addr/dbg_data         registered readback, every cycle
//   drop_cnt                  saturating count of single writes that were refused
module remap_lut_bank
    import remap_pkg::*;
#(
    parameter int DATA_W = 7,
    parameter int ADDR_W = 7,
    parameter int N_CH   = 2
) (
    input  logic                     okClk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     ld_start,
    input  logic                     ld_valid,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     ld_ready,
    output logic                     ld_done,
    output logic                     busy,
    input  logic [N_CH-1:0]          lk_valid,
    input  logic [N_CH*ADDR_W-1:0]   lk_addr,
    output logic [N_CH-1:0]          lk_rvalid,
    output logic [N_CH*DATA_W-1:0]   lk_data,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic [DROP_W-1:0]        drop_cnt
);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              load_last;
    logic              drop;

    // The clear and load walks share one pointer; they are never active together.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        mem_we     = 1'b0;
        mem_waddr  = ptr;
        mem_wdata  = '0;
        load_last  = 1'b0;
        case (state)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (clear) begin
                    ptr_next = '0;
                end else begin
                    ptr_next = ptr + 1'b1;
                    if (ptr == '1) state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_next = ST_CLEAR;
                    ptr_next   = '0;
                end else if (ld_start) begin
                    state_next = ST_LOAD;
                    ptr_next   = '0;
                end else if (wr_en) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr;
                    mem_wdata = wr_data;
                end
            end
            ST_LOAD: begin
                if (clear) begin
                    state_next = ST_CLEAR;
                    ptr_next   = '0;
                end else if (ld_start) begin
                    ptr_next = '0;
                end else if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = ld_data;
                    ptr_next  = ptr + 1'b1;
                    if (ptr == '1) begin
                        state_next = ST_IDLE;
                        load_last  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    // A single write is refused whenever the controller owns the table or a
    // higher-priority command arrives in the same cycle.
    assign drop     = wr_en && ((state != ST_IDLE) || clear || ld_start);
    assign busy     = (state != ST_IDLE);
    assign ld_ready = (state == ST_LOAD);

    always_ff @(posedge okClk) begin
        if (reset) begin
            state     <= ST_CLEAR;
            ptr       <= '0;
            ld_done   <= 1'b0;
            drop_cnt  <= '0;
            lk_rvalid <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            ld_done   <= load_last;
            lk_rvalid <= lk_valid;
            if (drop) drop_cnt <= sat_inc(drop_cnt);
        end
    end

    logic [(N_CH+1)*DATA_W-1:0] rd_all;

    remap_lut_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N_RD   (N_CH + 1)
    ) u_mem (
        .okClk (okClk),
        .reset (reset),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr ({dbg_addr, lk_addr}),
        .rdata (rd_all)
    );

    assign lk_data  = rd_all[N_CH*DATA_W-1:0];
    assign dbg_data = rd_all[N_CH*DATA_W +: DATA_W];

endmodule
